// File: rtl/mvm_layer_ctrl.sv
// mvm_layer_ctrl
//   Sequencer for one matrix-vector-multiply layer (y = W*x, M outputs,
//   N inputs, P MAC lanes). Carries no data: it steps the x-memory, the
//   weight ROM address, the MAC lane enables and the output lane mux, and
//   owns the input and output stream handshakes of the layer.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   s_valid     input element valid
//   m_ready     downstream accepts the current output element
//   s_ready     input element accepted when s_valid && s_ready
//   m_valid     output element available (lane out_sel)
//   xmem_wr_en  write current input element into x-memory
//   xmem_addr   x-memory write (LOAD) / read (COMPUTE) address, 0 otherwise
//   w_addr      weight ROM address g*N + k during COMPUTE, 0 otherwise
//   mac_en      all P lanes multiply-accumulate this cycle
//   mac_clr     with mac_en: lanes load the product instead of adding
//   out_sel     lane driving the output data
//   vec_done    one-cycle pulse after the final output of a vector is taken
module mvm_layer_ctrl #(
   parameter int unsigned M      = 16,
   parameter int unsigned N      = 12,
   parameter int unsigned P      = 4,
   parameter int unsigned MACLAT = 2,
   localparam int unsigned G     = M / P,
   localparam int unsigned XW    = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned WAW   = (G * N > 1) ? $clog2(G * N) : 1,
   localparam int unsigned PW    = (P > 1) ? $clog2(P) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           s_valid,
   input  logic           m_ready,
   output logic           s_ready,
   output logic           m_valid,
   output logic           xmem_wr_en,
   output logic [XW-1:0]  xmem_addr,
   output logic [WAW-1:0] w_addr,
   output logic           mac_en,
   output logic           mac_clr,
   output logic [PW-1:0]  out_sel,
   output logic           vec_done
);

   localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned WW = (MACLAT > 1) ? $clog2(MACLAT) : 1;

   localparam logic [XW-1:0]  N_LAST = XW'(N - 1);
   localparam logic [GW-1:0]  G_LAST = GW'(G - 1);
   localparam logic [WW-1:0]  W_LAST = WW'(MACLAT - 1);
   localparam logic [PW-1:0]  P_LAST = PW'(P - 1);
   localparam logic [WAW-1:0] N_STEP = WAW'(N);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      WAIT,
      OUTPUT
   } state_t;

   state_t        state;
   logic [XW-1:0] ld;
   logic [XW-1:0] k;
   logic [GW-1:0] g;
   logic [WW-1:0] w;
   logic [PW-1:0] l;

   // s_ready is only ever high in LOAD, so a handshake is just s_valid there.
   assign xmem_wr_en = s_valid && s_ready;

   // Outputs are registered alongside the state: each transition loads the
   // output values that belong to the state being entered, so every output
   // is a pure function of registered state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ld        <= '0;
         k         <= '0;
         g         <= '0;
         w         <= '0;
         l         <= '0;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         xmem_addr <= '0;
         w_addr    <= '0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         out_sel   <= '0;
         vec_done  <= 1'b0;
      end else begin
         vec_done <= 1'b0;
         case (state)
            IDLE: begin
               state     <= LOAD;
               s_ready   <= 1'b1;
               xmem_addr <= '0;
            end

            LOAD: begin
               if (s_valid) begin
                  if (ld == N_LAST) begin
                     ld        <= '0;
                     g         <= '0;
                     k         <= '0;
                     state     <= COMPUTE;
                     s_ready   <= 1'b0;
                     mac_en    <= 1'b1;
                     mac_clr   <= 1'b1;
                     xmem_addr <= '0;
                     w_addr    <= '0;
                  end else begin
                     ld        <= ld + 1'b1;
                     xmem_addr <= ld + 1'b1;
                  end
               end
            end

            COMPUTE: begin
               if (k == N_LAST) begin
                  k         <= '0;
                  w         <= '0;
                  state     <= WAIT;
                  mac_en    <= 1'b0;
                  mac_clr   <= 1'b0;
                  xmem_addr <= '0;
                  w_addr    <= '0;
               end else begin
                  k         <= k + 1'b1;
                  xmem_addr <= k + 1'b1;
                  // rows of one lane group are contiguous in the ROM
                  w_addr    <= w_addr + 1'b1;
                  mac_clr   <= 1'b0;
               end
            end

            WAIT: begin
               if (w == W_LAST) begin
                  w       <= '0;
                  l       <= '0;
                  state   <= OUTPUT;
                  m_valid <= 1'b1;
                  out_sel <= '0;
               end else begin
                  w <= w + 1'b1;
               end
            end

            OUTPUT: begin
               if (m_ready) begin
                  if (l == P_LAST) begin
                     l       <= '0;
                     out_sel <= '0;
                     m_valid <= 1'b0;
                     if (g != G_LAST) begin
                        g         <= g + 1'b1;
                        state     <= COMPUTE;
                        mac_en    <= 1'b1;
                        mac_clr   <= 1'b1;
                        xmem_addr <= '0;
                        w_addr    <= (WAW'(g) + 1'b1) * N_STEP;
                     end else begin
                        g         <= '0;
                        state     <= LOAD;
                        s_ready   <= 1'b1;
                        xmem_addr <= '0;
                        vec_done  <= 1'b1;
                     end
                  end else begin
                     l       <= l + 1'b1;
                     out_sel <= l + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mvm_layer_ctrl.md
# mvm_layer_ctrl

Control unit for a matrix-vector-multiply neural-network layer (y = W·x, M outputs, N inputs per vector, P parallel MAC lanes). It does not carry data. It sequences the input-vector memory, the weight ROM address, the MAC lane enables, and the output lane multiplexer. It also owns both stream handshakes (s_valid/s_ready in, m_valid/m_ready out) seen at the layer boundary. One instance sits beside the datapath inside each layer wrapper, e.g. M=16, N=12, P=4.

## Interface
- M, 16, outputs per vector; M % P == 0
- N, 12, input elements per vector
- P, 4, MAC lanes; one lane group of P outputs is computed per pass
- MACLAT, 2, cycles from mac_en to a valid accumulator result
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input element valid
- m_ready  in  1  downstream accepts output
- s_ready  out  1  input element accepted when s_valid && s_ready
- m_valid  out  1  output element available
- xmem_wr_en  out  1  write input element to x-memory (= s_valid && s_ready)
- xmem_addr  out  $clog2(N)  x-memory write address (LOAD) or read address (COMPUTE); 0 otherwise
- w_addr  out  $clog2(M/P*N)  weight ROM address = g*N + k in COMPUTE; 0 otherwise
- mac_en  out  1  all P lanes multiply-accumulate this cycle
- mac_clr  out  1  with mac_en: lanes load product instead of adding
- out_sel  out  $clog2(P)  lane driving data_out
- vec_done  out  1  one-cycle pulse on acceptance of the final (M-th) output of a vector

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT, OUTPUT. Counters: ld (0..N-1), k (0..N-1), g (0..M/P-1), w (0..MACLAT-1), l (0..P-1).
- Reset (reset=0): state IDLE, all counters 0. All outputs are 0: s_ready, m_valid, xmem_wr_en, mac_en, mac_clr, vec_done, addresses, out_sel.
- IDLE: unconditional move to LOAD on the next edge.
- LOAD: s_ready=1, xmem_addr=ld.
  - Each handshake writes one element and increments ld.
  - The handshake with ld==N-1 clears ld, sets g=0, k=0 and moves to COMPUTE.
- COMPUTE: mac_en=1, xmem_addr=k, w_addr=g*N+k, mac_clr=(k==0).
  - k increments every cycle, with no stall.
  - After k==N-1: k clears, w=0, move to WAIT.
- WAIT: mac_en=0. Counts MACLAT cycles, then moves to OUTPUT with l=0.
- OUTPUT: m_valid=1, out_sel=l.
  - Each handshake increments l.
  - The handshake with l==P-1 clears l. If g<M/P-1: g++ and move to COMPUTE. Otherwise: g=0, pulse vec_done, move to LOAD.
- Output element order: lane group 0 lanes 0..P-1, then group 1, and so on (y[0]..y[M-1]).
- Single-buffered: no input is accepted outside LOAD.
- s_valid is ignored outside LOAD. m_ready is ignored while m_valid=0.

## Timing
- All state and counters are registered. Handshake-derived outputs (xmem_wr_en) are combinational from s_valid and the registered state. All other outputs decode the registered state.
- s_ready first rises one cycle after reset deasserts (IDLE→LOAD).
- Stall-free cycle count per vector: N + (M/P)·(N+MACLAT+P). Defaults: 12 + 4·18 = 84 cycles.
- First output m_valid rises N+MACLAT cycles after the cycle of the last input handshake. Defaults: 14.
- m_valid stays high and out_sel stays stable until accepted. m_valid may not drop without a handshake.
- Back-to-back vectors: s_ready is high in the cycle after the final output handshake. A word presented then is accepted immediately.
- Reset asserted mid-operation: immediate return to IDLE. Any partial vector and pending outputs are discarded, m_valid drops asynchronously, and no vec_done is issued.
- Random s_valid/m_ready gaps only stretch LOAD/OUTPUT. COMPUTE and WAIT lengths are fixed.

## Test plan
- Reset: hold reset=0 for 3 cycles with s_valid=1 → s_ready=0 and m_valid=0 throughout. After release, s_ready=1 exactly one cycle later.
- Single vector, always-valid/always-ready, defaults → 12 writes at xmem_addr 0..11; then 4 passes of 12 mac_en cycles with w_addr g*12+0..11 and mac_clr only at k=0; 16 outputs with out_sel 0,1,2,3 repeating; vec_done at cycle 84.
- Output backpressure: m_ready=0 for 5 cycles during group 2, lane 1 → m_valid held, out_sel=1 stable, no COMPUTE started. Total becomes 89 cycles.
- Random s_valid/m_ready (50%) over 833 vectors → exactly 9996 input and 13328 output handshakes, no dropped or duplicated element, each output in order y[0..15].
- Back-to-back: s_valid high continuously → first element of vector 2 is accepted the cycle after the 16th output handshake of vector 1.
- Reset asserted during COMPUTE of group 1 → mac_en=0 and m_valid=0 at once. The next vector loads from xmem_addr 0, and the first output after it is that vector's y[0].
